// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: sole source of stall/flush for PC, IF/ID, ID/EX and EX/MEM.
// Resolves load-use hazards, taken branches, data-memory waits and the ecall drain to halt.
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_index,
   input  logic [4:0]       id_rs2_index,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd_index,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             mem_ecall,
   input  logic             mem_dm_req,
   input  logic             dm_ready,
   output logic             pc_stall,
   output logic             fd_stall,
   output logic             fd_flush,
   output logic             de_stall,
   output logic             de_flush,
   output logic             em_stall,
   output logic             em_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DM_WAIT = 2'd1,
      DRAIN   = 2'd2,
      HALT    = 2'd3
   } state_e;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic dm_wait, load_use;
   logic pc_stall_c, fd_stall_c, fd_flush_c, de_stall_c, de_flush_c, em_stall_c, em_flush_c;

   assign dm_wait  = mem_dm_req & ~dm_ready;
   assign load_use = ex_is_load & (ex_rd_index != 5'd0) &
                     ((id_rs1_used & (id_rs1_index == ex_rd_index)) |
                      (id_rs2_used & (id_rs2_index == ex_rd_index)));

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      pc_stall_c  = 1'b0;
      fd_stall_c  = 1'b0;
      fd_flush_c  = 1'b0;
      de_stall_c  = 1'b0;
      de_flush_c  = 1'b0;
      em_stall_c  = 1'b0;
      em_flush_c  = 1'b0;
      case (state_q)
         RUN: begin
            if (dm_wait) begin
               pc_stall_c = 1'b1;
               fd_stall_c = 1'b1;
               de_stall_c = 1'b1;
               em_stall_c = 1'b1;
               state_d    = DM_WAIT;
            end else if (mem_ecall) begin
               pc_stall_c  = 1'b1;
               fd_flush_c  = 1'b1;
               de_flush_c  = 1'b1;
               em_flush_c  = 1'b1;
               state_d     = DRAIN;
               drain_cnt_d = DRAIN_INIT;
            end else if (ex_branch_taken) begin
               fd_flush_c = 1'b1;
               de_flush_c = 1'b1;
            end else if (load_use) begin
               pc_stall_c = 1'b1;
               fd_stall_c = 1'b1;
               de_flush_c = 1'b1;
            end
         end
         DM_WAIT: begin
            // Frozen registers hold ecall/branch inputs; they are re-judged back in RUN.
            if (dm_ready) begin
               state_d = RUN;
            end else begin
               pc_stall_c = 1'b1;
               fd_stall_c = 1'b1;
               de_stall_c = 1'b1;
               em_stall_c = 1'b1;
            end
         end
         DRAIN: begin
            pc_stall_c = 1'b1;
            fd_flush_c = 1'b1;
            de_flush_c = 1'b1;
            em_flush_c = 1'b1;
            if (drain_cnt_q == '0) begin
               state_d = HALT;
            end else begin
               drain_cnt_d = drain_cnt_q - DW'(1);
            end
         end
         HALT: begin
            pc_stall_c = 1'b1;
            fd_flush_c = 1'b1;
            de_flush_c = 1'b1;
            em_flush_c = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      halted_d      = halted_q | (state_d == HALT);
      stall_count_d = stall_count_q;
      if (pc_stall_c && (state_q == RUN || state_q == DM_WAIT) && stall_count_q != CNT_MAX) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         drain_cnt_q   <= '0;
         halted_q      <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Flush dominates a stall of the same register; everything is quiet while in reset.
   assign pc_stall    = ~rst & pc_stall_c;
   assign fd_stall    = ~rst & fd_stall_c & ~fd_flush_c;
   assign fd_flush    = ~rst & fd_flush_c;
   assign de_stall    = ~rst & de_stall_c & ~de_flush_c;
   assign de_flush    = ~rst & de_flush_c;
   assign em_stall    = ~rst & em_stall_c & ~em_flush_c;
   assign em_flush    = ~rst & em_flush_c;
   assign halted      = halted_q;
   assign stall_count = stall_count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, random RUN traffic, and hand sequences for
// data-memory wait, ecall drain/halt, saturation and asynchronous reset.
module tb_pipe_hazard_ctrl;

   localparam int DRAIN_CYCLES = 2;
   localparam int CNT_W        = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Output pattern order: {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush}
   localparam logic [6:0] P_NONE = 7'b0000000;
   localparam logic [6:0] P_LU   = 7'b1100100;
   localparam logic [6:0] P_BR   = 7'b0010100;
   localparam logic [6:0] P_DM   = 7'b1101010;
   localparam logic [6:0] P_EC   = 7'b1010101;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       r1u;
      logic       r2u;
      logic [4:0] rd;
      logic       ld;
      logic       br;
      logic       ec;
      logic       dq;
      logic       dr;
      logic [6:0] exp;
      string      name;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs1_index, id_rs2_index, ex_rd_index;
   logic id_rs1_used, id_rs2_used, ex_is_load, ex_branch_taken, mem_ecall, mem_dm_req, dm_ready;
   logic pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, halted;
   logic [CNT_W-1:0] stall_count;
   logic [1:0] dbg_state;

   logic [6:0] exp_q[$];
   logic [CNT_W-1:0] exp_cnt;
   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd_index(ex_rd_index), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .mem_ecall(mem_ecall),
      .mem_dm_req(mem_dm_req), .dm_ready(dm_ready),
      .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
      .de_stall(de_stall), .de_flush(de_flush), .em_stall(em_stall), .em_flush(em_flush),
      .halted(halted), .stall_count(stall_count), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic r1u,
                               input logic r2u, input logic [4:0] rd, input logic ld,
                               input logic br, input logic ec, input logic dq, input logic dr,
                               input logic [6:0] exp, input string name);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.r1u = r1u; v.r2u = r2u; v.rd = rd; v.ld = ld;
      v.br = br; v.ec = ec; v.dq = dq; v.dr = dr; v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] outs();
      return {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush};
   endfunction

   // Drives one cycle of inputs, checks the same-cycle outputs, then the registered count.
   task automatic step(input vec_t v, input bit cnt_en);
      logic [6:0] e;
      id_rs1_index = v.rs1; id_rs2_index = v.rs2; id_rs1_used = v.r1u; id_rs2_used = v.r2u;
      ex_rd_index = v.rd; ex_is_load = v.ld; ex_branch_taken = v.br; mem_ecall = v.ec;
      mem_dm_req = v.dq; dm_ready = v.dr;
      exp_q.push_back(v.exp);
      if (cnt_en && v.exp[6] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      #2;
      e = exp_q.pop_front();
      chk(v.name, {25'd0, outs()}, {25'd0, e});
      @(posedge clk);
      #1;
      chk({v.name, " stall_count"}, {{(32-CNT_W){1'b0}}, stall_count}, {{(32-CNT_W){1'b0}}, exp_cnt});
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      #1;
      chk({name, " outputs in reset"}, {25'd0, outs()}, 32'd0);
      chk({name, " state in reset"}, {30'd0, dbg_state}, 32'd0);
      chk({name, " halted in reset"}, {31'd0, halted}, 32'd0);
      chk({name, " count in reset"}, {{(32-CNT_W){1'b0}}, stall_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cnt = '0;
   endtask

   initial begin
      vec_t vecs[9];
      vec_t v;
      logic [6:0] e;
      vecs[0] = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, P_LU,   "loaduse_rs1");
      vecs[1] = mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0, P_NONE, "loaduse_x0");
      vecs[2] = mk(5'd1, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 0, P_LU,   "loaduse_rs2");
      vecs[3] = mk(5'd1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0, 0, P_NONE, "rs2_unused");
      vecs[4] = mk(5'd9, 5'd0, 1, 0, 5'd9, 0, 0, 0, 0, 0, P_NONE, "not_load");
      vecs[5] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 0, P_BR,   "branch");
      vecs[6] = mk(5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0, 0, 0, P_BR,   "branch_over_loaduse");
      vecs[7] = mk(5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 1, 1, P_LU,   "dm_ready_no_wait");
      vecs[8] = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, P_NONE, "idle");

      exp_cnt = '0;
      v = mk(5'd4, 5'd4, 1, 1, 5'd4, 1, 1, 1, 1, 0, P_NONE, "init");
      id_rs1_index = v.rs1; id_rs2_index = v.rs2; id_rs1_used = 1; id_rs2_used = 1;
      ex_rd_index = v.rd; ex_is_load = 1; ex_branch_taken = 1; mem_ecall = 1;
      mem_dm_req = 1; dm_ready = 0;
      rst = 1'b1;
      #12;
      chk("reset outputs", {25'd0, outs()}, 32'd0);
      chk("reset state", {30'd0, dbg_state}, 32'd0);
      chk("reset halted", {31'd0, halted}, 32'd0);
      chk("reset count", {{(32-CNT_W){1'b0}}, stall_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) step(vecs[i], 1'b1);
      chk("table stays in RUN", {30'd0, dbg_state}, 32'd0);

      for (int i = 0; i < 24; i++) begin
         v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)), 1, P_NONE, "rand_run");
         if (v.br) e = P_BR;
         else if (v.ld && v.rd != 0 && ((v.r1u && v.rs1 == v.rd) || (v.r2u && v.rs2 == v.rd))) e = P_LU;
         else e = P_NONE;
         v.exp = e;
         step(v, 1'b1);
      end

      for (int i = 0; i < 18; i++) step(vecs[0], 1'b1);
      chk("count saturated", {{(32-CNT_W){1'b0}}, stall_count}, {{(32-CNT_W){1'b0}}, CNT_MAX});

      // Data-memory wait: three stalled cycles then release.
      do_reset("pre_dm");
      for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_DM, "dm_wait"), 1'b1);
      chk("dm state DM_WAIT", {30'd0, dbg_state}, 32'd1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, P_NONE, "dm_release"), 1'b1);
      chk("dm back to RUN", {30'd0, dbg_state}, 32'd0);
      chk("dm count +3", {{(32-CNT_W){1'b0}}, stall_count}, 32'd3);

      // dm_wait with ecall: wait first, ecall taken back in RUN, then drain to halt.
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, P_DM, "dm_over_ecall"), 1'b1);
      chk("ecall wait state", {30'd0, dbg_state}, 32'd1);
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, P_NONE, "dm_done_ecall"), 1'b1);
      chk("ecall back RUN", {30'd0, dbg_state}, 32'd0);
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, P_EC, "ecall_run"), 1'b1);
      chk("drain1 state", {30'd0, dbg_state}, 32'd2);
      chk("drain1 halted", {31'd0, halted}, 32'd0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_EC, "drain1"), 1'b0);
      chk("drain2 state", {30'd0, dbg_state}, 32'd2);
      chk("drain2 halted", {31'd0, halted}, 32'd0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_EC, "drain2"), 1'b0);
      chk("halt state", {30'd0, dbg_state}, 32'd3);
      chk("halt halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1, 1, 5'($urandom_range(1, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), P_EC, "halt_hold");
         step(v, 1'b0);
         chk("halt sticky", {31'd0, halted}, 32'd1);
      end

      do_reset("in_halt");
      chk("after halt reset state", {30'd0, dbg_state}, 32'd0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, P_DM, "dm_before_reset"), 1'b1);
      chk("pre reset DM_WAIT", {30'd0, dbg_state}, 32'd1);
      do_reset("in_dm_wait");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, P_NONE, "idle_after_reset"), 1'b1);
      chk("final state RUN", {30'd0, dbg_state}, 32'd0);
      chk("scoreboard drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
